// File: rtl/blob_analyzer.sv
// ---------------------------------------------------------------------------
// blob_analyzer: single-pass run-merge blob detector with bounding-box overlay
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module blob_analyzer #(
  parameter int H_ACTIVE      = 640,
  parameter int V_ACTIVE      = 480,
  parameter int MAX_BLOBS     = 8,
  parameter int GAP           = 1,
  parameter int MIN_W         = 4,
  parameter int MIN_H         = 4,
  parameter int TIMEOUT_TICKS = 64
) (
  input  logic        app_clk,
  input  logic        app_rst,
  input  logic        app_timer_tick,
  input  logic        mem_clk,
  input  logic        vid_preload_line,
  input  logic        vid_active_pix,
  input  logic [10:0] vid_hpos,
  input  logic [10:0] vid_vpos,
  input  logic        foregnd_px,
  output logic        vid_data_out
);

  localparam int          IW     = (MAX_BLOBS > 1) ? $clog2(MAX_BLOBS) : 1;
  localparam int          TW     = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [11:0] GAP12  = 12'(GAP);
  localparam logic [10:0] X_LAST = 11'(H_ACTIVE - 1);

  logic unused_pins;
  assign unused_pins = &{1'b0, mem_clk, vid_preload_line};

  logic [10:0] prev_h_q, prev_v_q, last_v_q, last_v_d;
  logic        run_open_q, run_open_d;
  logic [10:0] run_s_q, run_s_d, run_e_q, run_e_d, run_y_q, run_y_d;
  logic        cm_pend_q, cm_pend_d;
  logic [10:0] cm_s_q, cm_s_d, cm_e_q, cm_e_d, cm_y_q, cm_y_d;
  logic        fe_q, latch_q, overflow_q, overflow_d, ovl_q, ovl_d;
  logic [TW-1:0] tick_q, tick_d;

  logic [MAX_BLOBS-1:0] wk_v_q, wk_v_d, res_v_q, res_v_d, base_v, match;
  logic [10:0] wk_xmin_q [MAX_BLOBS], wk_xmax_q [MAX_BLOBS], wk_ymin_q [MAX_BLOBS], wk_ymax_q [MAX_BLOBS];
  logic [10:0] wk_xmin_d [MAX_BLOBS], wk_xmax_d [MAX_BLOBS], wk_ymin_d [MAX_BLOBS], wk_ymax_d [MAX_BLOBS];
  logic [10:0] res_xmin_q [MAX_BLOBS], res_xmax_q [MAX_BLOBS], res_ymin_q [MAX_BLOBS], res_ymax_q [MAX_BLOBS];
  logic [10:0] res_xmin_d [MAX_BLOBS], res_xmax_d [MAX_BLOBS], res_ymin_d [MAX_BLOBS], res_ymax_d [MAX_BLOBS];

  logic strobe, wrap;
  assign strobe = ((vid_hpos != prev_h_q) || (vid_vpos != prev_v_q)) &&
                  ({1'b0, vid_hpos} < 12'(H_ACTIVE)) && ({1'b0, vid_vpos} < 12'(V_ACTIVE));
  assign wrap   = strobe && (vid_vpos < last_v_q);
  assign last_v_d = strobe ? vid_vpos : last_v_q;

  // Run tracker: a closing run is handed to the commit stage for the next cycle.
  always_comb begin
    run_open_d = run_open_q;
    run_s_d    = run_s_q;
    run_e_d    = run_e_q;
    run_y_d    = run_y_q;
    cm_pend_d  = 1'b0;
    cm_s_d     = cm_s_q;
    cm_e_d     = cm_e_q;
    cm_y_d     = cm_y_q;
    if (strobe) begin
      if (run_open_q && (vid_vpos == run_y_q)) begin
        if (foregnd_px) begin
          run_e_d = vid_hpos;
          if (vid_hpos == X_LAST) begin
            run_open_d = 1'b0;
            cm_pend_d  = 1'b1;
            cm_s_d     = run_s_q;
            cm_e_d     = vid_hpos;
            cm_y_d     = run_y_q;
          end
        end else begin
          run_open_d = 1'b0;
          cm_pend_d  = 1'b1;
          cm_s_d     = run_s_q;
          cm_e_d     = run_e_q;
          cm_y_d     = run_y_q;
        end
      end else begin
        if (run_open_q) begin
          cm_pend_d = 1'b1;
          cm_s_d    = run_s_q;
          cm_e_d    = run_e_q;
          cm_y_d    = run_y_q;
        end
        run_open_d = foregnd_px;
        run_s_d    = vid_hpos;
        run_e_d    = vid_hpos;
        run_y_d    = vid_vpos;
        // A lone last-column pixel commits at once unless the commit slot is taken;
        // in that case it stays open and closes on the next strobe.
        if (foregnd_px && (vid_hpos == X_LAST) && !run_open_q) begin
          run_open_d = 1'b0;
          cm_pend_d  = 1'b1;
          cm_s_d     = vid_hpos;
          cm_e_d     = vid_hpos;
          cm_y_d     = vid_vpos;
        end
      end
    end
  end

  // Commit stage; during the frame-end latch the table is matched as already cleared.
  always_comb begin
    logic          found, free_found;
    logic [IW-1:0] lm, free_idx;
    logic [10:0]   ux0, ux1, uy0, uy1;
    found = 1'b0; free_found = 1'b0; lm = '0; free_idx = '0;
    ux0 = cm_s_q; ux1 = cm_e_q; uy0 = cm_y_q; uy1 = cm_y_q;
    for (int k = 0; k < MAX_BLOBS; k++) begin
      base_v[k] = wk_v_q[k] && !latch_q;
      match[k]  = base_v[k] &&
                  ({1'b0, cm_s_q} <= {1'b0, wk_xmax_q[k]} + GAP12) &&
                  ({1'b0, cm_e_q} + GAP12 >= {1'b0, wk_xmin_q[k]}) &&
                  ({1'b0, wk_ymax_q[k]} + 12'd1 >= {1'b0, cm_y_q});
      if (match[k]) begin
        if (wk_xmin_q[k] < ux0) ux0 = wk_xmin_q[k];
        if (wk_xmax_q[k] > ux1) ux1 = wk_xmax_q[k];
        if (wk_ymin_q[k] < uy0) uy0 = wk_ymin_q[k];
        if (wk_ymax_q[k] > uy1) uy1 = wk_ymax_q[k];
        if (!found) begin found = 1'b1; lm = IW'(k); end
      end
      if (!base_v[k] && !free_found) begin free_found = 1'b1; free_idx = IW'(k); end
    end
    wk_v_d = base_v;
    wk_xmin_d = wk_xmin_q; wk_xmax_d = wk_xmax_q; wk_ymin_d = wk_ymin_q; wk_ymax_d = wk_ymax_q;
    overflow_d = latch_q ? 1'b0 : overflow_q;
    if (cm_pend_q) begin
      if (found) begin
        wk_v_d = base_v & ~match;
        wk_v_d[lm] = 1'b1;
        wk_xmin_d[lm] = ux0; wk_xmax_d[lm] = ux1; wk_ymin_d[lm] = uy0; wk_ymax_d[lm] = uy1;
      end else if (free_found) begin
        wk_v_d[free_idx] = 1'b1;
        wk_xmin_d[free_idx] = cm_s_q; wk_xmax_d[free_idx] = cm_e_q;
        wk_ymin_d[free_idx] = cm_y_q; wk_ymax_d[free_idx] = cm_y_q;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  // Result table and timeout; a frame-end latch overrides a coinciding timeout.
  always_comb begin
    res_v_d = res_v_q;
    res_xmin_d = res_xmin_q; res_xmax_d = res_xmax_q; res_ymin_d = res_ymin_q; res_ymax_d = res_ymax_q;
    tick_d = tick_q;
    if (latch_q) begin
      tick_d = '0;
      res_xmin_d = wk_xmin_q; res_xmax_d = wk_xmax_q; res_ymin_d = wk_ymin_q; res_ymax_d = wk_ymax_q;
      for (int k = 0; k < MAX_BLOBS; k++)
        res_v_d[k] = wk_v_q[k] &&
                     ({1'b0, wk_xmax_q[k]} - {1'b0, wk_xmin_q[k]} + 12'd1 >= 12'(MIN_W)) &&
                     ({1'b0, wk_ymax_q[k]} - {1'b0, wk_ymin_q[k]} + 12'd1 >= 12'(MIN_H));
    end else if (tick_q == TW'(TIMEOUT_TICKS)) begin
      res_v_d = '0;
    end else if (app_timer_tick) begin
      tick_d = tick_q + TW'(1);
    end
  end

  always_comb begin
    ovl_d = 1'b0;
    for (int k = 0; k < MAX_BLOBS; k++)
      if (res_v_q[k] &&
          (((vid_hpos == res_xmin_q[k] || vid_hpos == res_xmax_q[k]) &&
            vid_vpos >= res_ymin_q[k] && vid_vpos <= res_ymax_q[k]) ||
           ((vid_vpos == res_ymin_q[k] || vid_vpos == res_ymax_q[k]) &&
            vid_hpos >= res_xmin_q[k] && vid_hpos <= res_xmax_q[k])))
        ovl_d = 1'b1;
    ovl_d = ovl_d && vid_active_pix;
  end

  always_ff @(posedge app_clk or posedge app_rst) begin
    if (app_rst) begin
      prev_h_q <= '0; prev_v_q <= '0; last_v_q <= '0;
      run_open_q <= 1'b0; run_s_q <= '0; run_e_q <= '0; run_y_q <= '0;
      cm_pend_q <= 1'b0; cm_s_q <= '0; cm_e_q <= '0; cm_y_q <= '0;
      fe_q <= 1'b0; latch_q <= 1'b0; overflow_q <= 1'b0; ovl_q <= 1'b0;
      tick_q <= '0; wk_v_q <= '0; res_v_q <= '0;
    end else begin
      prev_h_q <= vid_hpos; prev_v_q <= vid_vpos; last_v_q <= last_v_d;
      run_open_q <= run_open_d; run_s_q <= run_s_d; run_e_q <= run_e_d; run_y_q <= run_y_d;
      cm_pend_q <= cm_pend_d; cm_s_q <= cm_s_d; cm_e_q <= cm_e_d; cm_y_q <= cm_y_d;
      fe_q <= wrap; latch_q <= fe_q; overflow_q <= overflow_d; ovl_q <= ovl_d;
      tick_q <= tick_d; wk_v_q <= wk_v_d; res_v_q <= res_v_d;
    end
  end

  always_ff @(posedge app_clk) begin
    wk_xmin_q <= wk_xmin_d; wk_xmax_q <= wk_xmax_d; wk_ymin_q <= wk_ymin_d; wk_ymax_q <= wk_ymax_d;
    res_xmin_q <= res_xmin_d; res_xmax_q <= res_xmax_d; res_ymin_q <= res_ymin_d; res_ymax_q <= res_ymax_d;
  end

  assign vid_data_out = ovl_q;

endmodule

`default_nettype wire

// File: tb/tb_blob_analyzer.sv
// ---------------------------------------------------------------------------
// tb_blob_analyzer: directed bench for blob_analyzer (boxes, merge, overflow, timeout, reset)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_blob_analyzer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        act = 1'b1;
  logic        fg = 1'b0;
  logic [10:0] hpos = '0;
  logic [10:0] vpos = '0;
  logic        ovl;
  int          errors = 0;
  int          checks = 0;

  blob_analyzer dut (
    .app_clk          (clk),
    .app_rst          (rst),
    .app_timer_tick   (tick),
    .mem_clk          (1'b0),
    .vid_preload_line (1'b0),
    .vid_active_pix   (act),
    .vid_hpos         (hpos),
    .vid_vpos         (vpos),
    .foregnd_px       (fg),
    .vid_data_out     (ovl)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [44:0] box(input int k);
    return {dut.res_v_q[k], dut.res_xmin_q[k], dut.res_xmax_q[k], dut.res_ymin_q[k], dut.res_ymax_q[k]};
  endfunction

  function automatic logic [44:0] ebox(input int x0, input int x1, input int y0, input int y1);
    return {1'b1, 11'(x0), 11'(x1), 11'(y0), 11'(y1)};
  endfunction

  function automatic int nres();
    return $countones(dut.res_v_q);
  endfunction

  task automatic px(input int x, input int y, input bit f, input bit a, input int n);
    @(negedge clk);
    hpos = 11'(x); vpos = 11'(y); fg = f; act = a;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic pxc(input int x, input int y, input bit f, input bit a, input bit exp, input string tag);
    px(x, y, f, a, 1);
    @(posedge clk); #1;
    check(tag, 64'(ovl), 64'(exp));
  endtask

  task automatic run(input int y, input int s, input int e, input int n);
    px(s - 1, y, 0, 1, n);
    px(s, y, 1, 1, n);
    px(e, y, 1, 1, n);
    px(e + 1, y, 0, 1, n);
  endtask

  task automatic wrap();
    px(0, 0, 0, 1, 1);
    repeat (4) @(negedge clk);
  endtask

  // Two rectangles (x 21..200 and 251..329, y 6..99), optional bridge y 100..109 x 196..259.
  task automatic sweep(input bit bridge, input int n, input bit chk_ovl);
    for (int y = 6; y <= 99; y++) begin
      if (chk_ovl && y == 50) begin
        px(20, 50, 0, 1, n);
        pxc(21, 50, 1, 1, 1, "ovl_left_edge");
        pxc(100, 50, 1, 1, 0, "ovl_inside");
        px(200, 50, 1, 1, n);
        px(201, 50, 0, 1, n);
        px(250, 50, 0, 1, n);
        px(251, 50, 1, 1, n);
        pxc(329, 50, 1, 1, 1, "ovl_right_edge");
        px(330, 50, 0, 1, n);
      end else begin
        run(y, 21, 200, n);
        run(y, 251, 329, n);
      end
    end
    if (bridge)
      for (int y = 100; y <= 109; y++) run(y, 196, 259, n);
  endtask

  initial begin
    #12;
    check("reset_ovl", 64'(ovl), 64'd0);
    check("reset_results", 64'(nres()), 64'd0);
    check("reset_overflow", 64'(dut.overflow_q), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Two separate rectangles
    sweep(0, 1, 0);
    wrap();
    check("two_rect_count", 64'(nres()), 64'd2);
    check("two_rect_box0", 64'(box(0)), 64'(ebox(21, 200, 6, 99)));
    check("two_rect_box1", 64'(box(1)), 64'(ebox(251, 329, 6, 99)));

    // Bridge merges both rectangles into one box
    sweep(1, 1, 1);
    wrap();
    check("bridge_count", 64'(nres()), 64'd1);
    check("bridge_box0", 64'(box(0)), 64'(ebox(21, 329, 6, 109)));

    // Every position held two cycles, then a long column at x=639
    sweep(1, 2, 1);
    for (int i = 0; i < 150; i++) px(639, 110 + i, 0, 1, 1);
    wrap();
    check("held_count", 64'(nres()), 64'd1);
    check("held_box0", 64'(box(0)), 64'(ebox(21, 329, 6, 109)));

    // 2x2 blob is below the minimum size
    run(200, 10, 11, 1);
    run(201, 10, 11, 1);
    wrap();
    check("small_blob_count", 64'(nres()), 64'd0);

    // Ten 5x5 blobs on one band: eight slots, overflow
    for (int y = 300; y <= 304; y++)
      for (int i = 0; i < 10; i++) run(y, 20 + 40 * i, 24 + 40 * i, 1);
    repeat (3) @(negedge clk);
    check("overflow_set", 64'(dut.overflow_q), 64'd1);
    wrap();
    check("overflow_count", 64'(nres()), 64'd8);
    check("overflow_box0", 64'(box(0)), 64'(ebox(20, 24, 300, 304)));
    check("overflow_box7", 64'(box(7)), 64'(ebox(300, 304, 300, 304)));
    check("overflow_cleared", 64'(dut.overflow_q), 64'd0);

    // Timeout with positions held
    pxc(20, 300, 0, 1, 1, "timeout_before");
    for (int i = 0; i < 63; i++) begin
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
    end
    @(posedge clk); #1;
    check("timeout_63_ticks", 64'(ovl), 64'd1);
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("timeout_64_ovl", 64'(ovl), 64'd0);
    check("timeout_64_results", 64'(nres()), 64'd0);

    // Mid-frame asynchronous reset
    sweep(0, 1, 0);
    wrap();
    pxc(21, 50, 0, 0, 0, "ovl_gated_inactive");
    pxc(21, 51, 0, 1, 1, "ovl_before_reset");
    #1 rst = 1'b1;
    #1;
    check("reset_async_ovl", 64'(ovl), 64'd0);
    check("reset_async_results", 64'(nres()), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    pxc(21, 52, 0, 1, 0, "ovl_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
